// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-port round-robin arbiter in front of a single APB
// master port. Decodes the address to a one-hot pselx, runs the SETUP/ACCESS
// phases with pready wait states and returns read data plus an error flag.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYC cycles with pready low.
module apb_master_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              write0,
  input  logic              write1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata_out,
  output logic              err_out,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  output logic [2:0]        pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata
);

  localparam int unsigned TCNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

`ifdef APB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              r_state, w_state;
  logic                r_owner, w_owner;
  logic                r_prio, w_prio;
  logic                r_write, w_write;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic [2:0]          r_sel, w_sel;
  logic [TCNT_W-1:0]   r_tcnt, w_tcnt;
  logic [TCNT_W-1:0]   w_tcnt_inc;
  logic                w_win;
  logic                w_apb;
  logic                w_pen;
  logic                w_done;
  logic                w_err;
  logic [DATA_W-1:0]   w_rdata;

  // Registered output images (next values computed in the combinational block)
  logic                r_gnt0, r_gnt1, r_done0, r_done1, r_err, r_penable, r_pwrite;
  logic [2:0]          r_pselx;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata, r_rdata;
  logic                w_gnt0, w_gnt1, w_done0, w_done1, w_err_o, w_penable, w_pwrite;
  logic [2:0]          w_pselx;
  logic [ADDR_W-1:0]   w_paddr;
  logic [DATA_W-1:0]   w_pwdata, w_rdata_o;

  // Top six address bits select one of three 64 MB slave windows
  function automatic logic [2:0] decode(input logic [ADDR_W-1:0] a);
    logic [5:0] top;
    top = a[ADDR_W-1 -: 6];
    case (top)
      6'h20:   decode = 3'b001;
      6'h21:   decode = 3'b010;
      6'h22:   decode = 3'b100;
      default: decode = 3'b000;
    endcase
  endfunction

  assign w_tcnt_inc = r_tcnt + TCNT_W'(1);

  // Next-state, arbitration, request latch and next output values
  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_prio  = r_prio;
    w_write = r_write;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_sel   = r_sel;
    w_tcnt  = r_tcnt;
    w_win   = 1'b0;
    w_apb   = 1'b0;
    w_pen   = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_rdata = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          // Both requesting: the pointer names the port not served last
          w_win   = (req0 && req1) ? r_prio : req1;
          w_owner = w_win;
          w_prio  = ~w_win;
          w_write = w_win ? write1 : write0;
          w_addr  = w_win ? addr1  : addr0;
          w_wdata = w_win ? wdata1 : wdata0;
          w_sel   = decode(w_addr);
          if (w_sel != 3'b000) begin
            w_state = ST_SETUP;
            w_apb   = 1'b1;
          end else begin
            w_state = ST_RESP;
            w_done  = 1'b1;
            w_err   = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        w_state = ST_ACCESS;
        w_tcnt  = '0;
        w_apb   = 1'b1;
        w_pen   = 1'b1;
      end
      ST_ACCESS: begin
        if (pready) begin
          w_state = ST_RESP;
          w_done  = 1'b1;
          w_rdata = r_write ? '0 : prdata;
        end else if (TIMEOUT_EN && (w_tcnt_inc == TCNT_W'(TIMEOUT_CYC))) begin
          w_state = ST_RESP;
          w_done  = 1'b1;
          w_err   = 1'b1;
        end else begin
          w_tcnt  = w_tcnt_inc;
          w_apb   = 1'b1;
          w_pen   = 1'b1;
        end
      end
      ST_RESP: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    w_pselx   = w_apb ? w_sel   : 3'b000;
    w_penable = w_pen;
    w_pwrite  = w_apb ? w_write : 1'b0;
    w_paddr   = w_apb ? w_addr  : '0;
    w_pwdata  = w_apb ? w_wdata : '0;
    w_gnt0    = w_apb & ~w_owner;
    w_gnt1    = w_apb &  w_owner;
    w_done0   = w_done & ~w_owner;
    w_done1   = w_done &  w_owner;
    w_err_o   = w_err;
    w_rdata_o = w_rdata;
  end

  // State, latch and output registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state   <= ST_IDLE;
      r_owner   <= 1'b0;
      r_prio    <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_sel     <= 3'b000;
      r_tcnt    <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_pselx   <= 3'b000;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_state   <= w_state;
      r_owner   <= w_owner;
      r_prio    <= w_prio;
      r_write   <= w_write;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_sel     <= w_sel;
      r_tcnt    <= w_tcnt;
      r_gnt0    <= w_gnt0;
      r_gnt1    <= w_gnt1;
      r_done0   <= w_done0;
      r_done1   <= w_done1;
      r_err     <= w_err_o;
      r_rdata   <= w_rdata_o;
      r_pselx   <= w_pselx;
      r_penable <= w_penable;
      r_pwrite  <= w_pwrite;
      r_paddr   <= w_paddr;
      r_pwdata  <= w_pwdata;
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign err_out   = r_err;
  assign rdata_out = r_rdata;
  assign pselx     = r_pselx;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares the bridge's single APB master port between two requesters (port 0: AHB slave-side transfer path; port 1: configuration/maintenance requester). Round-robin arbitration picks a winner, the block decodes the address to a one-hot `pselx`, sequences the APB SETUP and ACCESS phases with `pready` wait states, and returns read data plus an error flag. All APB outputs are registered; downstream `apb_interface` logic consumes them unchanged.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYC`, 16, ACCESS cycles with `pready` low before abort (used only with `APB_TIMEOUT_EN`)

- `hclk`  in  1  clock; all logic on rising edge
- `hresetn`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1  transfer request; held high until the matching `done`
- `write0`, `write1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  ADDR_W  transfer address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `gnt0`, `gnt1`  out  1  high while that port owns the APB bus (SETUP and ACCESS states)
- `done0`, `done1`  out  1  one-cycle completion pulse
- `rdata_out`  out  DATA_W  read data; valid in the `done` cycle
- `err_out`  out  1  error flag; valid in the `done` cycle
- `pready`  in  1  APB slave ready
- `prdata`  in  DATA_W  APB read data
- `pselx`  out  3  one-hot slave select
- `penable`, `pwrite`  out  1  APB enable / direction
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: if any `reqN` is high, choose a winner, latch its `write`/`addr`/`wdata`, and decode:
  - 0x8000_0000–0x83FF_FFFF → 3'b001
  - 0x8400_0000–0x87FF_FFFF → 3'b010
  - 0x8800_0000–0x8BFF_FFFF → 3'b100
  - Hit → SETUP. Miss → RESP with error; no APB activity.
- SETUP: `pselx` = decode, `penable` = 0, `paddr`/`pwrite`/`pwdata` driven from the latch. Always → ACCESS.
- ACCESS: `penable` = 1, other APB outputs held.
  - `pready` = 1: capture `prdata` (reads only; writes return 0), `err` = 0 → RESP.
  - `pready` = 0: stay in ACCESS.
- RESP: `doneN` pulses for the owner with `rdata_out`/`err_out`. APB outputs = 0. → IDLE.
- Arbitration is round-robin. With both requests high, grant the port not served last. After reset, port 0 has priority.
- Dropping `reqN` after grant is ignored; the transfer completes and `done` still pulses.
- The same port may win again only if the other port is not requesting.

## Timing
- All outputs reset to 0 asynchronously; state → IDLE; round-robin pointer → port 0.
- Zero-wait read: request seen in IDLE at cycle 0 → SETUP cycle 1 → ACCESS cycle 2 (`pready` = 1) → `done`/`rdata_out` cycle 3 → IDLE cycle 4. Each wait state adds one cycle.
- Decode miss: `done` + `err_out` = 1 in cycle 1.
- Outside RESP, `rdata_out` = 0 and `err_out` = 0.
- Minimum spacing between APB transfers is 4 cycles (no back-to-back SETUP).
- Reset asserted mid-transfer: APB outputs drop immediately and no `done` is issued. The requester re-requests.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with `pready` = 0.
  - When the count reaches `TIMEOUT_CYC`, the block moves to RESP with `err_out` = 1 and `rdata_out` = 0.
  - `pselx`/`penable` drop in that RESP cycle.
  - `pready` arriving in the same cycle as the limit wins: normal completion, no error.
- `APB_TIMEOUT_EN` undefined:
  - ACCESS waits indefinitely.
  - `err_out` is asserted only on a decode miss.

## Test plan
- Read, port 0, `addr0` = 0x8000_0010, `pready` tied 1, `prdata` = 0xA5A5_0001 → `pselx` = 001 in cycles 1–2, `penable` high in cycle 2, `done0` + `rdata_out` = 0xA5A5_0001 in cycle 3, `err_out` = 0.
- Write, port 1, `addr1` = 0x8800_0004, `wdata1` = 0x1234_5678, `pready` low for 3 ACCESS cycles → `pselx` = 100, `pwrite` = 1, `pwdata` = 0x1234_5678 held, `done1` in cycle 6, `rdata_out` = 0.
- `req0` and `req1` held high for 3 transfers from reset → grants alternate 0, 1, 0.
- Decode miss, `addr0` = 0x9000_0000 → `done0` + `err_out` = 1 in cycle 1; `pselx`/`penable` never asserted.
- `hresetn` pulled low during ACCESS → all outputs 0 immediately, no `done`; after release, a new `req1` is granted first only if `req0` is low.
- With `APB_TIMEOUT_EN` and `TIMEOUT_CYC` = 16, `pready` stuck low → `done` + `err_out` = 1 after 16 ACCESS cycles, `rdata_out` = 0.
